// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - pipeline request/response and data-memory port bundle for the load/store unit
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [3:0]  mem_rwe;
  logic [31:0] mem_dout;

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_dout,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_din, mem_rwe
  );

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_dout,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_din, mem_rwe
  );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - MEM-stage load/store controller: funct3 to memory command, byte-split misaligned accesses
module load_store_unit #(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  load_store_unit_if.slave bus
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_SPLIT  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        store_q, store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] asm_q, asm_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_din_q, mem_din_d;
  logic [3:0]  mem_rwe_q, mem_rwe_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;

  logic        req_ready;
  logic        accept;
  logic        illegal;
  logic        misaligned;
  logic [2:0]  cmd_code;
  logic [1:0]  last_idx;
  logic [1:0]  idx_nx;

  assign req_ready = (state_q == S_IDLE) || (state_q == S_DONE);
  assign accept    = bus.req_valid && req_ready;
  assign last_idx  = funct3_q[1] ? 2'd3 : 2'd1;
  assign idx_nx    = idx_q + 2'd1;

  // Decode of the incoming request, only meaningful on an accept cycle
  always_comb begin
    if (bus.req_store) begin
      illegal = bus.req_funct3[2] || (bus.req_funct3[1:0] == 2'b11);
    end else begin
      illegal = (bus.req_funct3[1:0] == 2'b11) || (bus.req_funct3 == 3'b110);
    end
    misaligned = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                 ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    if (bus.req_store) begin
      case (bus.req_funct3[1:0])
        2'b00:   cmd_code = 3'b101;
        2'b01:   cmd_code = 3'b110;
        default: cmd_code = 3'b111;
      endcase
    end else begin
      case (bus.req_funct3)
        3'b000:  cmd_code = 3'b000;
        3'b100:  cmd_code = 3'b001;
        3'b001:  cmd_code = 3'b010;
        3'b101:  cmd_code = 3'b011;
        default: cmd_code = 3'b100;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    store_d      = store_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    idx_d        = idx_q;
    asm_d        = asm_q;
    mem_addr_d   = mem_addr_q;
    mem_din_d    = mem_din_q;
    mem_rwe_d    = 4'b0000;
    resp_rdata_d = 32'h0;
    resp_err_d   = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          store_d  = bus.req_store;
          funct3_d = bus.req_funct3;
          addr_d   = bus.req_addr;
          wdata_d  = bus.req_wdata;
          if (illegal || (misaligned && !ALLOW_MISALIGNED)) begin
            state_d    = S_DONE;
            resp_err_d = 1'b1;
          end else if (misaligned) begin
            state_d    = S_SPLIT;
            idx_d      = 2'd0;
            asm_d      = 32'h0;
            mem_addr_d = bus.req_addr;
            mem_din_d  = {24'h0, bus.req_wdata[7:0]};
            mem_rwe_d  = bus.req_store ? 4'b0101 : 4'b1001;
          end else begin
            state_d    = S_ACCESS;
            mem_addr_d = bus.req_addr;
            mem_din_d  = bus.req_wdata;
            mem_rwe_d  = {~bus.req_store, cmd_code};
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: begin
        state_d      = S_DONE;
        resp_rdata_d = store_q ? 32'h0 : bus.mem_dout;
      end
      S_SPLIT: begin
        asm_d[{idx_q, 3'b000} +: 8] = bus.mem_dout[7:0];
        if (idx_q == last_idx) begin
          state_d = S_DONE;
          if (!store_q) begin
            // Byte cycles fetch raw bytes, so the final extension is applied here
            case (funct3_q)
              3'b001:  resp_rdata_d = {{16{asm_d[15]}}, asm_d[15:0]};
              3'b101:  resp_rdata_d = {16'h0, asm_d[15:0]};
              default: resp_rdata_d = asm_d;
            endcase
          end
        end else begin
          idx_d      = idx_nx;
          mem_addr_d = addr_q + {30'h0, idx_nx};
          mem_din_d  = {24'h0, wdata_q[{idx_nx, 3'b000} +: 8]};
          mem_rwe_d  = store_q ? 4'b0101 : 4'b1001;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      store_q      <= 1'b0;
      funct3_q     <= 3'b000;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      idx_q        <= 2'd0;
      asm_q        <= 32'h0;
      mem_addr_q   <= 32'h0;
      mem_din_q    <= 32'h0;
      mem_rwe_q    <= 4'b0000;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      store_q      <= store_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      idx_q        <= idx_d;
      asm_q        <= asm_d;
      mem_addr_q   <= mem_addr_d;
      mem_din_q    <= mem_din_d;
      mem_rwe_q    <= mem_rwe_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = (state_q == S_DONE);
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_din    = mem_din_q;
  assign bus.mem_rwe    = mem_rwe_q;
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Requester-side controller for the data memory port in the MEM stage. It accepts one load or store per handshake from the pipeline and translates RISC-V funct3 into the memory's 4-bit `read_write_en` command encoding. Aligned accesses complete in one memory cycle. Misaligned accesses are either split into byte-wide memory cycles, with load data assembled and extended here, or rejected with an error. The response is a one-cycle pulse back to the pipeline, which holds its stage stalled until then.

## Interface
- `ALLOW_MISALIGNED`, default 1: 1 = split misaligned accesses into byte cycles; 0 = reject them with `resp_err`.
- `clk  in  1`: single clock; all state on rising edge.
- `rst_n  in  1`: reset, synchronous, active-low.
- `req_valid  in  1`: request present.
- `req_ready  out  1`: unit can accept (IDLE or DONE).
- `req_store  in  1`: 1 = store, 0 = load.
- `req_funct3  in  3`: RISC-V funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `req_addr  in  32`: byte address.
- `req_wdata  in  32`: store data, low-aligned.
- `resp_valid  out  1`: one-cycle completion pulse.
- `resp_rdata  out  32`: load result, extended; 0 for stores and errors.
- `resp_err  out  1`: valid with `resp_valid`; illegal funct3 or rejected misalignment.
- `mem_addr  out  32`: byte address to the data memory.
- `mem_din  out  32`: write data to the data memory.
- `mem_rwe  out  4`: memory command; bit3 = read; [2:0] = 000 LB, 001 LBU, 010 LH, 011 LHU, 100 LW, 101 SB, 110 SH, 111 SW; idle = 4'b0000.
- `mem_dout  in  32`: combinational read data from the data memory.

## Operation
- States: IDLE, ACCESS, SPLIT, DONE.
  - Accept when `req_valid && req_ready`. Latch store, funct3, addr and wdata.
  - Byte count: 1 for B/BU, 2 for H/HU, 4 for W.
- Misalignment:
  - Halfword is misaligned when `addr[0]=1`.
  - Word is misaligned when `addr[1:0]!=0`.
- Error cases:
  - Illegal funct3: load with 011/110/111; store with anything other than 000/001/010.
  - Misaligned access with `ALLOW_MISALIGNED=0`.
  - On error: IDLE→DONE directly, `resp_err=1`, no memory cycle issued.
- Aligned access: →ACCESS.
  - Drive `mem_addr`=addr.
  - `mem_rwe` = {1, mapped code} for loads; {0, 101/110/111} for stores.
  - `mem_din`=wdata.
  - Capture `mem_dout` at end of the cycle, then →DONE.
- Misaligned access with `ALLOW_MISALIGNED=1`: →SPLIT.
  - Issue byte cycle i = 0..n-1 at `mem_addr` = addr+i, mod 2^32 (wraps).
  - Loads: `mem_rwe=4'b1001` (LBU); captured `mem_dout[7:0]` goes into assembly bits [8i+7:8i].
  - Stores: `mem_rwe=4'b0101` (SB), `mem_din[7:0]` = wdata byte i.
  - After byte n-1: →DONE.
  - Final load result: sign-extend from bit 15 (H) or zero-extend (HU); W is unchanged.
- DONE: `resp_valid=1` for exactly one cycle.
  - `req_ready=1`, so a new accept goes straight to ACCESS/SPLIT/DONE.
  - Otherwise →IDLE.
- All `mem_*` outputs are registered. `mem_rwe=0` in IDLE and DONE, and whenever no access is in progress.
- `resp_rdata`/`resp_err` hold their value only while `resp_valid=1`; they are 0 otherwise.

## Timing
- Reset: the edge with `rst_n=0` forces IDLE.
  - After that edge: `req_ready=1`, `resp_valid=0`, `resp_rdata=0`, `resp_err=0`, `mem_addr=0`, `mem_din=0`, `mem_rwe=0`.
- Reset mid-SPLIT aborts the access with no response.
  - Store bytes already written stay written. This is accepted behaviour.
- Accept on edge E0:
  - Aligned: memory command during E0..E1, `resp_valid` during E1..E2 (2-cycle latency).
  - Misaligned with n bytes: byte commands during E0..E(n), `resp_valid` during E(n)..E(n+1).
  - Error: `resp_valid` during E0..E1.
- Back-to-back aligned requests issue one memory cycle every 2 cycles.
- A store's write lands at the edge closing its memory cycle, before `resp_valid` rises.
- `req_ready=0` in ACCESS/SPLIT; `req_valid` is ignored there.
- No backpressure on the response path.

## Test plan
- Aligned LW at addr 0x100, mem word 0x8765_4321 → `mem_rwe=4'b1100` for 1 cycle, `resp_rdata=0x8765_4321`, latency 2.
- LB at 0x103, word 0x80xx_xxxx → `mem_rwe=4'b1000`, `resp_rdata=0xFFFF_FF80`.
  - Same case with LBU (funct3 100) → `resp_rdata=0x0000_0080`.
- SH 0xBEEF at 0x102 over word 0x1111_1111 → `mem_rwe=4'b0110` once; word becomes 0xBEEF_1111.
- Misaligned LW at 0x101, bytes 0x101..0x104 = 11,22,33,44 → four 4'b1001 cycles at 0x101..0x104, `resp_rdata=0x4433_2211`, latency 5.
  - Same case with `ALLOW_MISALIGNED=0` → `resp_err=1` one cycle after accept, no `mem_rwe` activity.
- Misaligned SW 0xAABBCCDD at 0xFFFF_FFFE → SB cycles at 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0, 0x1 with bytes DD, CC, BB, AA.
  - Separately, illegal funct3 011 on a store → `resp_err=1`.
- `rst_n` low during the 2nd byte of a split store → next edge IDLE, `mem_rwe=0`, no `resp_valid`, byte 0 written.
